// File: rtl/lemming_fate_monitor_pkg.sv
// Shared types and constants for the lemming fate monitor: FSM state
// encoding, the default splat threshold and the packed status bit layout.
package lemming_pkg;

    typedef enum logic [1:0] {
        GND   = 2'd0,
        FALL  = 2'd1,
        SPLAT = 2'd2
    } fate_state_e;

    localparam int SPLAT_CYCLES_DEF = 20;

    // Bit positions inside the packed walker status vector.
    localparam int STATUS_W = 4;
    localparam int WL       = 0;
    localparam int WR       = 1;
    localparam int AAAH     = 2;
    localparam int DIG      = 3;

    // True when exactly one status bit is set (the walker's one-hot contract).
    function automatic logic is_onehot(input logic [STATUS_W-1:0] s);
        logic [2:0] ones;
        ones = 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
        return (ones == 3'd1);
    endfunction

endpackage

// File: rtl/lemming_fate_monitor_if.sv
// Bundle of walker status inputs and monitor results.  The walker side
// (or a bench) uses the master view, the monitor uses the slave view.
interface lemming_fate_monitor_if #(
    parameter int CNT_W = 8,
    parameter int FL_W  = 5
);
    // Walker status (one-hot by contract)
    logic             walk_left;
    logic             walk_right;
    logic             aaah;
    logic             digging;

    // Masked status toward display/scoring
    logic             walk_left_o;
    logic             walk_right_o;
    logic             aaah_o;
    logic             digging_o;

    // Fate and statistics
    logic             dead;
    logic [FL_W-1:0]  fall_len;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] turn_cnt;
    logic [CNT_W-1:0] dig_cnt;
    logic             proto_err;

    modport master (
        output walk_left, walk_right, aaah, digging,
        input  walk_left_o, walk_right_o, aaah_o, digging_o,
        input  dead, fall_len, fall_cnt, turn_cnt, dig_cnt, proto_err
    );

    modport slave (
        input  walk_left, walk_right, aaah, digging,
        output walk_left_o, walk_right_o, aaah_o, digging_o,
        output dead, fall_len, fall_cnt, turn_cnt, dig_cnt, proto_err
    );

endinterface

// File: rtl/lemming_fate_monitor_sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping and can be
// frozen with hold.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only when asked, not frozen and not yet full.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !hold && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/lemming_fate_monitor.sv
// Lemming fate monitor: times each fall of the walker, latches death when a
// fall runs past the splat threshold, masks the walker status once dead,
// and keeps saturating turn/dig/fall statistics plus a sticky one-hot error.
module lemming_fate_monitor
    import lemming_pkg::*;
#(
    parameter int SPLAT_CYCLES = SPLAT_CYCLES_DEF,
    parameter int CNT_W        = 8,
    parameter int FL_W         = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    lemming_fate_monitor_if.slave mon
);

    // fall_len has to be able to represent the saturated value
    // SPLAT_CYCLES+1, otherwise a deadly fall could never be recognised.
    generate
        if ((SPLAT_CYCLES + 1) > ((1 << FL_W) - 1)) begin : g_fl_w_too_narrow
            $error("FL_W is too narrow to hold SPLAT_CYCLES+1");
        end
        if (SPLAT_CYCLES < 1) begin : g_splat_too_small
            $error("SPLAT_CYCLES must be at least 1");
        end
    endgenerate

    localparam logic [FL_W-1:0] LEN_SURVIVE = FL_W'(SPLAT_CYCLES);
    localparam logic [FL_W-1:0] LEN_MAX     = FL_W'(SPLAT_CYCLES + 1);

    logic [STATUS_W-1:0] status;

    fate_state_e       state_q, state_d;
    logic [FL_W-1:0]   fall_len_q, fall_len_d;
    logic              dead_q, dead_d;
    logic              proto_err_q, proto_err_d;
    logic              prev_wl_q, prev_wl_d;
    logic              prev_wr_q, prev_wr_d;
    logic              prev_dig_q, prev_dig_d;

    logic              landed;
    logic              splat_entry;
    logic              stats_hold;
    logic              turn_ev;
    logic              dig_ev;

    // Pack the walker status into one vector for indexed access.
    always_comb begin
        status       = '0;
        status[WL]   = mon.walk_left;
        status[WR]   = mon.walk_right;
        status[AAAH] = mon.aaah;
        status[DIG]  = mon.digging;
    end

    // Fall-timing FSM: next state, next fall length and landing/death events.
    always_comb begin
        state_d     = state_q;
        fall_len_d  = fall_len_q;
        landed      = 1'b0;
        splat_entry = 1'b0;
        unique case (state_q)
            GND: begin
                if (status[AAAH]) begin
                    state_d    = FALL;
                    fall_len_d = FL_W'(1);
                end else begin
                    fall_len_d = '0;
                end
            end
            FALL: begin
                if (status[AAAH]) begin
                    if (fall_len_q < LEN_MAX) begin
                        fall_len_d = fall_len_q + 1'b1;
                    end
                end else if (fall_len_q > LEN_SURVIVE) begin
                    // Too long in the air: keep the length visible for scoring.
                    state_d     = SPLAT;
                    splat_entry = 1'b1;
                end else begin
                    state_d    = GND;
                    fall_len_d = '0;
                    landed     = 1'b1;
                end
            end
            SPLAT: begin
                state_d = SPLAT;
            end
            default: begin
                state_d    = GND;
                fall_len_d = '0;
            end
        endcase
        dead_d = (state_d == SPLAT);
    end

    // Statistics events, previous-status capture and the sticky one-hot check.
    always_comb begin
        stats_hold  = (state_q == SPLAT) || splat_entry;
        turn_ev     = (status[WR] & prev_wl_q) | (status[WL] & prev_wr_q);
        dig_ev      = status[DIG] & ~prev_dig_q;
        prev_wl_d   = prev_wl_q;
        prev_wr_d   = prev_wr_q;
        prev_dig_d  = prev_dig_q;
        proto_err_d = proto_err_q;
        if (state_q != SPLAT) begin
            prev_wl_d  = status[WL];
            prev_wr_d  = status[WR];
            prev_dig_d = status[DIG];
            if (!is_onehot(status)) begin
                proto_err_d = 1'b1;
            end
        end
    end

    // State and flag registers; reset wins over everything including SPLAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GND;
            fall_len_q  <= '0;
            dead_q      <= 1'b0;
            proto_err_q <= 1'b0;
            prev_wl_q   <= 1'b0;
            prev_wr_q   <= 1'b0;
            prev_dig_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fall_len_q  <= fall_len_d;
            dead_q      <= dead_d;
            proto_err_q <= proto_err_d;
            prev_wl_q   <= prev_wl_d;
            prev_wr_q   <= prev_wr_d;
            prev_dig_q  <= prev_dig_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (landed),
        .hold  (stats_hold),
        .q     (mon.fall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_turn_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (turn_ev),
        .hold  (stats_hold),
        .q     (mon.turn_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dig_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dig_ev),
        .hold  (stats_hold),
        .q     (mon.dig_cnt)
    );

    // Zero-latency masking: the dead register gates the live status.
    assign mon.walk_left_o  = status[WL]   & ~dead_q;
    assign mon.walk_right_o = status[WR]   & ~dead_q;
    assign mon.aaah_o       = status[AAAH] & ~dead_q;
    assign mon.digging_o    = status[DIG]  & ~dead_q;

    assign mon.dead      = dead_q;
    assign mon.fall_len  = fall_len_q;
    assign mon.proto_err = proto_err_q;

endmodule

// File: tb/tb_lemming_fate_monitor.sv
// Bench for lemming_fate_monitor: table-driven vectors, hand-written corner
// sequences and randomized traffic, all compared each cycle against a
// behavioural fate model.
module tb_lemming_fate_monitor;

    localparam int S     = 20;
    localparam int CNT_W = 8;
    localparam int FL_W  = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    lemming_fate_monitor_if #(.CNT_W(CNT_W), .FL_W(FL_W)) mif ();

    lemming_fate_monitor #(
        .SPLAT_CYCLES (S),
        .CNT_W        (CNT_W),
        .FL_W         (FL_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mif)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the lemming is airborne while m_fall > 0.
    bit m_valid = 1'b0;
    bit m_dead, m_perr, m_pwl, m_pwr, m_pdig;
    int m_fall, m_fcnt, m_tcnt, m_dcnt;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit wl, input bit wr, input bit a, input bit dg, input bit r);
        bit died;
        int ones;
        if (r) begin
            m_valid = 1'b1;
            m_dead = 0; m_perr = 0; m_pwl = 0; m_pwr = 0; m_pdig = 0;
            m_fall = 0; m_fcnt = 0; m_tcnt = 0; m_dcnt = 0;
            return;
        end
        if (m_dead) return;
        died = 1'b0;
        if (a) begin
            m_fall = (m_fall + 1 > S + 1) ? S + 1 : m_fall + 1;
        end else if (m_fall > S) begin
            m_dead = 1'b1;
            died   = 1'b1;
        end else if (m_fall > 0) begin
            m_fall = 0;
            m_fcnt = sat_inc(m_fcnt);
        end
        ones = 0;
        ones += wl; ones += wr; ones += a; ones += dg;
        if (ones != 1) m_perr = 1'b1;
        if (!died) begin
            if ((wr && m_pwl) || (wl && m_pwr)) m_tcnt = sat_inc(m_tcnt);
            if (dg && !m_pdig) m_dcnt = sat_inc(m_dcnt);
        end
        m_pwl = wl; m_pwr = wr; m_pdig = dg;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check masking, clock, check registered state.
    task automatic cycle(input bit wl, input bit wr, input bit a, input bit dg, input bit r);
        mif.walk_left  = wl;
        mif.walk_right = wr;
        mif.aaah       = a;
        mif.digging    = dg;
        reset          = r;
        #1;
        if (m_valid) begin
            chk("walk_left_o",  mif.walk_left_o,  32'(wl && !m_dead));
            chk("walk_right_o", mif.walk_right_o, 32'(wr && !m_dead));
            chk("aaah_o",       mif.aaah_o,       32'(a  && !m_dead));
            chk("digging_o",    mif.digging_o,    32'(dg && !m_dead));
        end
        @(posedge clk);
        model_step(wl, wr, a, dg, r);
        @(negedge clk);
        chk("dead",      mif.dead,      32'(m_dead));
        chk("fall_len",  mif.fall_len,  32'(m_fall));
        chk("fall_cnt",  mif.fall_cnt,  32'(m_fcnt));
        chk("turn_cnt",  mif.turn_cnt,  32'(m_tcnt));
        chk("dig_cnt",   mif.dig_cnt,   32'(m_dcnt));
        chk("proto_err", mif.proto_err, 32'(m_perr));
    endtask

    typedef struct {
        bit wl, wr, a, dg, rst;
        bit e_dead;
        int e_len;
        int e_fcnt;
        bit e_perr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        mif.walk_left  = 1'b0;
        mif.walk_right = 1'b0;
        mif.aaah       = 1'b0;
        mif.digging    = 1'b0;

        // Reset, walk left, survivable fall of exactly S cycles, land.
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 0; i < S; i++) vecs.push_back('{0, 0, 1, 0, 0, 0, i + 1, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wl, vecs[i].wr, vecs[i].a, vecs[i].dg, vecs[i].rst);
            chk($sformatf("vec%0d_dead", i), mif.dead,      32'(vecs[i].e_dead));
            chk($sformatf("vec%0d_len", i),  mif.fall_len,  32'(vecs[i].e_len));
            chk($sformatf("vec%0d_fcnt", i), mif.fall_cnt,  32'(vecs[i].e_fcnt));
            chk($sformatf("vec%0d_perr", i), mif.proto_err, 32'(vecs[i].e_perr));
        end

        // Deadly fall of S+1 cycles, then everything frozen and masked.
        for (int i = 0; i < S + 1; i++) cycle(0, 0, 1, 0, 0);
        chk("splat_peak_len", mif.fall_len, 32'(S + 1));
        chk("splat_peak_dead", mif.dead, 32'd0);
        cycle(0, 1, 0, 0, 0);
        chk("splat_dead", mif.dead, 32'd1);
        chk("splat_len_held", mif.fall_len, 32'(S + 1));
        chk("splat_fcnt", mif.fall_cnt, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cycle(i % 2 == 0, i % 2 == 1, 0, i % 3 == 0, 0);
            chk("splat_wr_masked", mif.walk_right_o, 32'd0);
        end
        chk("splat_turn_frozen", mif.turn_cnt, 32'd0);
        chk("splat_dig_frozen", mif.dig_cnt, 32'd0);
        chk("splat_perr_frozen", mif.proto_err, 32'd0);
        chk("splat_still_dead", mif.dead, 32'd1);

        // Turn saturation and dig episodes.
        cycle(0, 0, 0, 0, 1);
        chk("rst_from_splat_dead", mif.dead, 32'd0);
        for (int i = 0; i < 300; i++) cycle(i % 2 == 0, i % 2 == 1, 0, 0, 0);
        chk("turn_sat", mif.turn_cnt, 32'(CMAX));
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            cycle(0, 0, 0, 1, 0);
            cycle(1, 0, 0, 0, 0);
        end
        chk("dig_three", mif.dig_cnt, 32'd3);
        chk("turn_still_sat", mif.turn_cnt, 32'(CMAX));

        // Sticky protocol error.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        chk("perr_set", mif.proto_err, 32'd1);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
        chk("perr_sticky", mif.proto_err, 32'd1);
        cycle(1, 0, 0, 0, 1);
        chk("perr_cleared", mif.proto_err, 32'd0);

        // Reset in the middle of a fall restarts the timing.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 1);
        chk("midfall_rst_len", mif.fall_len, 32'd0);
        cycle(0, 0, 1, 0, 0);
        chk("midfall_restart_len", mif.fall_len, 32'd1);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);
        chk("midfall_len10", mif.fall_len, 32'd10);
        cycle(1, 0, 0, 0, 0);
        chk("midfall_fcnt", mif.fall_cnt, 32'd1);
        chk("midfall_dead", mif.dead, 32'd0);

        // Randomized traffic against the model.
        for (int ep = 0; ep < 400; ep++) begin
            int r;
            int n;
            int k;
            logic [3:0] v;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                n = $urandom_range(1, 25);
                for (int j = 0; j < n; j++) cycle(0, 0, 1, 0, 0);
                k = $urandom_range(0, 2);
                cycle(k == 0, k == 1, 0, k == 2, 0);
            end else if (r <= 5) begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) begin
                    k = $urandom_range(0, 2);
                    cycle(k == 0, k == 1, 0, k == 2, 0);
                end
            end else if (r == 6) begin
                v = 4'($urandom_range(0, 15));
                cycle(v[0], v[1], v[2], v[3], 0);
            end else if (r == 7) begin
                v = 4'($urandom_range(0, 15));
                cycle(v[0], v[1], v[2], v[3], 1);
            end else begin
                n = $urandom_range(2, 8);
                for (int j = 0; j < n; j++) cycle(j % 2 == 0, j % 2 == 1, 0, 0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
